// File: rtl/crc8_bit_serializer_pkg.sv
// Shared types and constants for the CRC-8 bit serializer slice.
// The CRC constants describe the downstream serial CRC stage
// (x^8+x^5+x^4+1, preset 0xFF) so that models of that stage and of this
// feeder agree on one definition.
package crc8_ser_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = 3;

  localparam logic [BYTE_W-1:0] CRC_POLY   = 8'h31;
  localparam logic [BYTE_W-1:0] CRC_PRESET = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    CRC_CAP = 2'd2,
    CRC_TX  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/crc8_bit_serializer_if.sv
// Byte-level valid/ready handshake feeding the serializer.
// The master side supplies bytes; the slave side (the serializer) accepts them.
interface crc8_bit_serializer_if;
  import crc8_ser_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_last,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_last,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/crc8_bit_serializer_ser_shift8.sv
// 8-bit load/shift register with a 3-bit bit index.
// MSB_FIRST=1 presents bit 7 first and shifts left; MSB_FIRST=0 presents
// bit 0 first and shifts right. A load always restarts the index at 0.
// Used both for payload bytes and for the captured CRC byte.
module ser_shift8
  import crc8_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [BYTE_W-1:0]    data_i,
  output logic                 bit_o,
  output logic [BIT_IDX_W-1:0] idxNext_o,
  output logic                 idxLast_o
);

  logic [BYTE_W-1:0]    shReg_q, shReg_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;

  // Next contents: load wins over shift, otherwise hold.
  always_comb begin
    shReg_d = shReg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shReg_d = data_i;
      idx_d   = '0;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        shReg_d = {shReg_q[BYTE_W-2:0], 1'b0};
      end else begin
        shReg_d = {1'b0, shReg_q[BYTE_W-1:1]};
      end
      idx_d = idx_q + BIT_IDX_W'(1);
    end
  end

  // Register the shift contents and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shReg_q <= '0;
      idx_q   <= '0;
    end else begin
      shReg_q <= shReg_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_o     = MSB_FIRST ? shReg_q[BYTE_W-1] : shReg_q[0];
  assign idxNext_o = idx_d;
  assign idxLast_o = (idx_q == '1);

endmodule

// File: rtl/crc8_bit_serializer.sv
// Byte-to-bit feeder for the serial CRC-8 stage.
// Accepts bytes over valid/ready, drives one bit per clock to the CRC stage
// and mirrors it onto the serial line, captures the CRC at end of frame.
// Build option: define CRC_APPEND_EN to shift the captured CRC byte onto the
// line after the payload; left undefined, the line carries payload only.
module crc8_bit_serializer
  import crc8_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  crc8_bit_serializer_if.slave     in_if,
  output logic                     crc_bit,
  output logic                     crc_init,
  input  logic [BYTE_W-1:0]        crc_in,
  output logic                     line_bit,
  output logic                     line_valid,
  output logic [BYTE_W-1:0]        crc_out,
  output logic                     frame_done,
  output logic                     underrun
);

  ser_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 inReady_q, inReady_d;
  logic                 crcInit_q, crcInit_d;
  logic                 lineValid_q, lineValid_d;
  logic                 dataPhase_q, dataPhase_d;
  logic                 frameDone_q, frameDone_d;
  logic                 underrun_q, underrun_d;
  logic [BYTE_W-1:0]    crcOut_q, crcOut_d;

  logic                 handshake;
  logic                 shLoad;
  logic                 shShift;
  logic [BYTE_W-1:0]    shData;
  logic                 shBit;
  logic [BIT_IDX_W-1:0] shIdxNext;
  logic                 shIdxLast;

  assign handshake = in_if.in_valid & inReady_q;

  ser_shift8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (shLoad),
    .shift_i   (shShift),
    .data_i    (shData),
    .bit_o     (shBit),
    .idxNext_o (shIdxNext),
    .idxLast_o (shIdxLast)
  );

  // Next-state logic: frame sequencing, shift control and end-of-frame pulses.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    crcOut_d    = crcOut_q;
    frameDone_d = 1'b0;
    underrun_d  = 1'b0;
    shLoad      = 1'b0;
    shShift     = 1'b0;
    shData      = in_if.in_data;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = DATA;
          shLoad  = 1'b1;
          last_d  = in_if.in_last;
        end
      end

      DATA: begin
        if (!shIdxLast) begin
          shShift = 1'b1;
        end else if (last_q) begin
          state_d = CRC_CAP;
        end else if (handshake) begin
          // Back-to-back byte: reload without a bubble on the line.
          shLoad = 1'b1;
          last_d = in_if.in_last;
        end else begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end
      end

      CRC_CAP: begin
        // The CRC stage has absorbed the final data bit by now.
        crcOut_d = crc_in;
        shLoad   = 1'b1;
        shData   = crc_in;
`ifdef CRC_APPEND_EN
        state_d  = CRC_TX;
`else
        state_d     = IDLE;
        frameDone_d = 1'b1;
`endif
      end

`ifdef CRC_APPEND_EN
      CRC_TX: begin
        if (!shIdxLast) begin
          shShift = 1'b1;
        end else begin
          state_d     = IDLE;
          frameDone_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output comes from a flop.
  always_comb begin
    inReady_d   = (state_d == IDLE) ||
                  ((state_d == DATA) && (shIdxNext == '1) && !last_d);
    crcInit_d   = (state_d != DATA);
    lineValid_d = (state_d == DATA) || (state_d == CRC_TX);
    dataPhase_d = (state_d == DATA);
  end

  // FSM state, latched last flag, captured CRC and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      inReady_q   <= 1'b0;
      crcInit_q   <= 1'b1;
      lineValid_q <= 1'b0;
      dataPhase_q <= 1'b0;
      frameDone_q <= 1'b0;
      underrun_q  <= 1'b0;
      crcOut_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      inReady_q   <= inReady_d;
      crcInit_q   <= crcInit_d;
      lineValid_q <= lineValid_d;
      dataPhase_q <= dataPhase_d;
      frameDone_q <= frameDone_d;
      underrun_q  <= underrun_d;
      crcOut_q    <= crcOut_d;
    end
  end

  assign in_if.in_ready = inReady_q;
  assign crc_init       = crcInit_q;
  assign line_valid     = lineValid_q;
  assign line_bit       = shBit & lineValid_q;
  assign crc_bit        = shBit & dataPhase_q;
  assign crc_out        = crcOut_q;
  assign frame_done     = frameDone_q;
  assign underrun       = underrun_q;

endmodule
